serial_to_parallel_converter: RTL and testbench
===============================================

Name: serial_to_parallel_converter

Overview:
- Receive-side counterpart of the team's parallel-to-serial stage. Sits directly downstream of it.
- Consumes the LSB-first serial stream over a ser_valid/ser_ready handshake.
- Reassembles N-bit words and presents them on a par_valid/par_ready output interface.
- Holds one completed word in the output register plus one in the assembly register, so a stalled sink does not drop bits.

Parameters:
N  4  word width in bits; legal range N >= 2

Ports:
clk        input   1  rising-edge clock
rst        input   1  asynchronous, active-high reset
ser_valid  input   1  upstream has a valid serial bit on ser_data
ser_data   input   1  serial bit; first bit of a word is bit 0 (LSB first)
ser_ready  output  1  block accepts ser_data this cycle
par_valid  output  1  par_data holds a complete word
par_data   output  N  assembled word
par_ready  input   1  downstream accepts par_data this cycle

Behaviour:
- Reset (rst=1, asynchronous assert, deassert sampled on clk):
  - state=COLLECT, bit count=0, assembly register=0, par_data=0, par_valid=0.
  - ser_ready=1 after reset deassertion.
  - Reset mid-word or mid-hold discards all partial and held data.
- Handshakes:
  - Serial bit accepted on a rising edge when ser_valid && ser_ready.
  - Word consumed on a rising edge when par_valid && par_ready.
  - ser_ready is decoded from state only: ser_ready = (state==COLLECT). It never depends combinationally on ser_valid.
- Assembly:
  - Each accepted bit shifts the assembly register right with ser_data inserted at bit N-1.
  - After N accepted bits, the first bit received sits in bit 0.
  - Bit counter width is $clog2(N). It increments per accepted bit and wraps N-1 -> 0 on the Nth bit.
- State COLLECT:
  - ser_ready=1.
  - On acceptance of the Nth bit with the output register free (par_valid==0, or par_ready==1 this cycle): par_data <= completed word, par_valid <= 1, count <= 0, stay in COLLECT.
  - On acceptance of the Nth bit with the output register occupied and not draining (par_valid && !par_ready): completed word stays in the assembly register, go to HOLD.
  - Latency: par_valid rises on the same edge that accepts the Nth bit.
- State HOLD:
  - ser_ready=0; ser_valid is ignored.
  - On par_ready with par_valid=1: par_data <= held word, par_valid stays 1, count <= 0, go to COLLECT. ser_ready reasserts the cycle after the drain.
- par_valid/par_data stability: once par_valid=1, par_data is stable and par_valid stays 1 until the consuming edge.
- par_valid drop: if the output register drains with no new word completing on that edge, par_valid <= 0 and par_data retains its last value.
- Simultaneous events: on an edge where the output drains and the Nth bit arrives in COLLECT, the new word loads directly and par_valid stays 1, with no bubble.
- Throughput: with par_ready held 1 and ser_valid held 1, one word every N cycles sustained.
- ser_valid low mid-word: counter and assembly register freeze; no timeout.
- No words are created, duplicated, or lost: the sequence out equals the sequence of complete N-bit groups in.

Test Plan:
1. Reset, then ser_valid=1, bits 1,1,0,1 on consecutive cycles, par_ready=1 -> par_valid high for exactly one cycle after the 4th accepting edge, par_data=4'hB; ser_ready=1 throughout.
2. Continuous stream 0xB,0x6,0xF (LSB first, 12 bits), par_ready=1 -> par_valid pulses every 4 cycles carrying B, 6, F in order; no ser_ready deassertion.
3. Send 0x3 with par_ready=0, then 0xC with par_ready=0 -> after 8th bit state=HOLD, ser_ready=0, par_data=0x3. Raise par_ready for 1 cycle -> par_data=0xC, par_valid=1, ser_ready=1 the following cycle. Second par_ready consumes 0xC, then par_valid=0.
4. Output occupied with 0x5; par_ready asserted on exactly the edge the 4th bit of 0xA is accepted -> par_data=0xA, par_valid never drops, state stays COLLECT.
5. Bits 1,0 then ser_valid=0 for 5 cycles, then 1,1 -> par_data=4'hD, assembled correctly across the gap.
6. Assert rst asynchronously (between edges) after 2 bits, and again while in HOLD -> par_valid=0, par_data=0, ser_ready=1 immediately after deassertion; next 4 bits 0,1,1,1 yield par_data=4'hE.

Source files
------------

// File: rtl/serial_to_parallel_converter.sv
// Rebuilds LSB-first serial bits into N-bit words; the word is valid on the edge that accepts its last bit.
// A stalled sink parks one finished word in the assembly register and drops ser_ready until the output register drains.
module serial_to_parallel_converter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ser_valid,
    input  logic         ser_data,
    output logic         ser_ready,
    output logic         par_valid,
    output logic [N-1:0] par_data,
    input  logic         par_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  asm_reg;

    logic          accept;
    logic          drain;
    logic          last_bit;
    logic [N-1:0]  next_word;

    assign ser_ready = (state == COLLECT);
    assign accept    = ser_valid && ser_ready;
    assign drain     = par_valid && par_ready;
    assign last_bit  = (bit_cnt == LAST_IDX);
    assign next_word = {ser_data, asm_reg[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            bit_cnt   <= '0;
            asm_reg   <= '0;
            par_data  <= '0;
            par_valid <= 1'b0;
        end else begin
            // Default drop on drain; a word loading on the same edge overrides it.
            if (drain)
                par_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        asm_reg <= next_word;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (!par_valid || par_ready) begin
                                par_data  <= next_word;
                                par_valid <= 1'b1;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        par_data  <= asm_reg;
                        par_valid <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Scoreboard bench for serial_to_parallel_converter: words pushed as sent, popped when consumed.
module tb_serial_to_parallel_converter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ser_valid = 1'b0;
    logic         ser_data = 1'b0;
    logic         ser_ready;
    logic         par_valid;
    logic [N-1:0] par_data;
    logic         par_ready = 1'b0;

    logic [N-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           stalls = 0;

    serial_to_parallel_converter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .par_valid (par_valid),
        .par_data  (par_data),
        .par_ready (par_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Consumed words are compared against the scoreboard just before the consuming edge.
    always @(negedge clk) begin
        if (!rst && par_valid && par_ready) begin
            if (exp_q.size() == 0)
                check_val("unexpected_word", {28'd0, par_data}, 32'hFFFF_FFFF);
            else
                check_val("word", {28'd0, par_data}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic send_bit(input logic b);
        logic acc;
        int   cyc;
        ser_valid = 1'b1;
        ser_data  = b;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = ser_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) check_val("bit_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [N-1:0] w);
        exp_q.push_back(w);
        for (int i = 0; i < N; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int cycles);
        ser_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases away from the edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3 rst = 1'b1;
        ser_valid = 1'b0;
        #1;
        check_val({tag, "_valid"}, {31'd0, par_valid}, 32'd0);
        check_val({tag, "_data"}, {28'd0, par_data}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check_val({tag, "_ser_ready"}, {31'd0, ser_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: single word
        do_reset("rst0");
        par_ready = 1'b1;
        send_word(4'hB);
        check_val("t1_valid", {31'd0, par_valid}, 32'd1);
        check_val("t1_data", {28'd0, par_data}, 32'hB);
        check_val("t1_ser_ready", {31'd0, ser_ready}, 32'd1);
        idle(1);
        check_val("t1_valid_drop", {31'd0, par_valid}, 32'd0);

        // 2: back-to-back words, no stalls
        stalls = 0;
        send_word(4'hB);
        send_word(4'h6);
        send_word(4'hF);
        ser_valid = 1'b0;
        check_val("t2_stalls", stalls, 32'd0);
        check_val("t2_last", {28'd0, par_data}, 32'hF);
        idle(1);

        // 3: stalled sink forces HOLD
        par_ready = 1'b0;
        send_word(4'h3);
        send_word(4'hC);
        ser_valid = 1'b0;
        check_val("t3_hold_ser_ready", {31'd0, ser_ready}, 32'd0);
        check_val("t3_hold_data", {28'd0, par_data}, 32'h3);
        check_val("t3_hold_valid", {31'd0, par_valid}, 32'd1);
        par_ready = 1'b1;
        @(posedge clk);
        #1 par_ready = 1'b0;
        check_val("t3_second_data", {28'd0, par_data}, 32'hC);
        check_val("t3_second_valid", {31'd0, par_valid}, 32'd1);
        check_val("t3_ser_ready_back", {31'd0, ser_ready}, 32'd1);
        idle(2);
        check_val("t3_still_held", {28'd0, par_data}, 32'hC);
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("t3_empty", {31'd0, par_valid}, 32'd0);

        // 4: drain and load on the same edge
        par_ready = 1'b0;
        send_word(4'h5);
        exp_q.push_back(4'hA);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_val("t4_occupied_valid", {31'd0, par_valid}, 32'd1);
        check_val("t4_occupied_data", {28'd0, par_data}, 32'h5);
        par_ready = 1'b1;
        send_bit(1'b1);
        ser_valid = 1'b0;
        check_val("t4_valid", {31'd0, par_valid}, 32'd1);
        check_val("t4_data", {28'd0, par_data}, 32'hA);
        check_val("t4_ser_ready", {31'd0, ser_ready}, 32'd1);
        idle(1);
        check_val("t4_drained", {31'd0, par_valid}, 32'd0);

        // 5: gap in ser_valid mid-word
        exp_q.push_back(4'hD);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(5);
        check_val("t5_no_early_word", {31'd0, par_valid}, 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        ser_valid = 1'b0;
        check_val("t5_data", {28'd0, par_data}, 32'hD);
        idle(1);

        // 6: reset mid-word and in HOLD, then recover
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset("rst_mid");
        par_ready = 1'b0;
        send_word(4'h1);
        send_word(4'h2);
        ser_valid = 1'b0;
        check_val("t6_hold", {31'd0, ser_ready}, 32'd0);
        do_reset("rst_hold");
        par_ready = 1'b1;
        send_word(4'hE);
        ser_valid = 1'b0;
        check_val("t6_valid", {31'd0, par_valid}, 32'd1);
        check_val("t6_data", {28'd0, par_data}, 32'hE);
        idle(2);

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
